// File: rtl/demux8way16_hold.sv
// Registered 1-to-8 demultiplexer: one producer fans out to eight consumers.
// Each channel has a one-deep holding register and a valid/ack handshake.
module demux8way16_hold #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN,
  input  logic [2:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic [7:0]       out_valid,
  input  logic [7:0]       ack,
  output logic [7:0]       count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

  chan_state_t      state_q [8];
  chan_state_t      state_d [8];
  logic [WIDTH-1:0] data_q  [8];
  logic [7:0]       count_q;
  logic             accept;

  // Handshake: a word transfers on an edge where in_valid && in_ready; a
  // consumer takes its word on an edge where ack[k] && out_valid[k]. A full
  // channel being acked this cycle can be refilled in the same edge.
  assign in_ready = (state_q[s] == EMPTY) || ack[s];
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        EMPTY: if (accept && (s == 3'(k))) state_d[k] = FULL;
        FULL: begin
          if (accept && (s == 3'(k))) state_d[k] = FULL;
          else if (ack[k])            state_d[k] = EMPTY;
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) state_q[k] <= EMPTY;
    end else begin
      for (int k = 0; k < 8; k++) state_q[k] <= state_d[k];
    end
  end

  // Data registers keep their last word after an ack; only the valid bit drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) data_q[k] <= '0;
    end else if (accept) begin
      data_q[s] <= IN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count_q <= 8'd0;
    else if (accept) count_q <= count_q + 8'd1;
  end

  always_comb begin
    out_valid = 8'h00;
    for (int k = 0; k < 8; k++) out_valid[k] = (state_q[k] == FULL);
  end

  assign A     = data_q[0];
  assign B     = data_q[1];
  assign C     = data_q[2];
  assign D     = data_q[3];
  assign W     = data_q[4];
  assign X     = data_q[5];
  assign Y     = data_q[6];
  assign Z     = data_q[7];
  assign count = count_q;

endmodule

// File: tb/tb_demux8way16_hold.sv
// Bench for demux8way16_hold: directed scenarios plus random traffic checked
// against a channel-array reference model.
`timescale 1ns/100ps
module tb_demux8way16_hold;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [2:0]  s;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, c, d, w, x, y, z;
  logic [7:0]  out_valid;
  logic [7:0]  ack;
  logic [7:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: held words, valid flags, accept counter
  logic [15:0] m_data [8];
  logic [7:0]  m_valid;
  logic [7:0]  m_count;

  demux8way16_hold dut (
    .clk(clk), .rst(rst), .IN(in_data), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .A(a), .B(b), .C(c), .D(d), .W(w), .X(x), .Y(y),
    .Z(z), .out_valid(out_valid), .ack(ack), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] chan_out(int k);
    case (k)
      0: return a;  1: return b;  2: return c;  3: return d;
      4: return w;  5: return x;  6: return y;  default: return z;
    endcase
  endfunction

  function automatic logic m_ready();
    return !m_valid[s] || ack[s];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_data[k] = 16'h0;
    m_valid = 8'h00;
    m_count = 8'd0;
  endtask

  // Acks retire words first, then an accepted word (re)fills its channel.
  task automatic model_step();
    logic acc;
    acc = in_valid && m_ready();
    m_valid = m_valid & ~ack;
    if (acc) begin
      m_data[s]  = in_data;
      m_valid[s] = 1'b1;
      m_count    = m_count + 8'd1;
    end
  endtask

  task automatic cycle();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; ack = 8'h00; in_data = 16'h0; s = 3'd0;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      cycle();
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready s=%0d got %b want 1", k, in_ready);
      end
      n_cmp++;
    end
    n_cmp++;
    if (out_valid !== 8'h00 || count !== 8'd0) begin
      n_fail++; $display("FAIL reset_state out_valid=%h count=%0d want 00/0", out_valid, count);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (chan_out(k) !== 16'h0) begin
        n_fail++; $display("FAIL reset_data ch%0d got %0d want 0", k, chan_out(k));
      end
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_fill();
    logic [15:0] vals [8] = '{16'd3, 16'd9, 16'd17, 16'd5, 16'd11, 16'd2, 16'd24, 16'd8};
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; s = 3'(k); in_data = vals[k]; ack = 8'h00;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_in_ready s=%0d got %b want 1", k, in_ready);
      end
      cycle();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (chan_out(k) !== vals[k]) begin
        n_fail++; $display("FAIL fill_data ch%0d got %0d want %0d", k, chan_out(k), vals[k]);
      end
    end
    n_cmp++;
    if (out_valid !== 8'hFF || count !== 8'd8) begin
      n_fail++; $display("FAIL fill_flags out_valid=%h count=%0d want ff/8", out_valid, count);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; s = 3'd2; in_data = 16'd100; ack = 8'h00;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall_ready got %b want 0", in_ready);
    end
    cycle();
    n_cmp++;
    if (c !== 16'd17) begin
      n_fail++; $display("FAIL bp_stall_hold C got %0d want 17", c);
    end
    ack = 8'h04;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ack_ready got %b want 1", in_ready);
    end
    cycle();
    in_valid = 1'b0; ack = 8'h00;
    n_cmp++;
    if (c !== 16'd100 || out_valid[2] !== 1'b1 || count !== 8'd9) begin
      n_fail++; $display("FAIL bp_refill C=%0d v2=%b count=%0d want 100/1/9", c, out_valid[2], count);
    end
  endtask

  task automatic test_drain();
    ack = 8'hA5;
    cycle();
    ack = 8'h00;
    n_cmp++;
    if (out_valid !== 8'h5A) begin
      n_fail++; $display("FAIL drain_valid got %h want 5a", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (chan_out(k) !== m_data[k]) begin
        n_fail++; $display("FAIL drain_data ch%0d got %0d want %0d", k, chan_out(k), m_data[k]);
      end
    end
  endtask

  task automatic test_spurious_ack();
    ack = 8'hFF;
    cycle();
    n_cmp++;
    if (out_valid !== 8'h00) begin
      n_fail++; $display("FAIL spur_clear got %h want 00", out_valid);
    end
    cycle();
    cycle();
    ack = 8'h00;
    n_cmp++;
    if (out_valid !== 8'h00 || count !== m_count) begin
      n_fail++; $display("FAIL spur_flags out_valid=%h count=%0d want 00/%0d", out_valid, count, m_count);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (chan_out(k) !== m_data[k]) begin
        n_fail++; $display("FAIL spur_data ch%0d got %0d want %0d", k, chan_out(k), m_data[k]);
      end
    end
  endtask

  task automatic test_streaming();
    int wrap_seen = 0;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; s = 3'd7; ack = 8'h80; in_data = 16'(i);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready i=%0d got %b want 1", i, in_ready);
      end
      cycle();
      n_cmp++;
      if (z !== 16'(i) || out_valid[7] !== 1'b1) begin
        n_fail++; $display("FAIL stream_z i=%0d got %0d/%b want %0d/1", i, z, out_valid[7], i);
      end
      if (i == 255) begin
        wrap_seen = 1;
        n_cmp++;
        if (count !== 8'd0) begin
          n_fail++; $display("FAIL stream_wrap count got %0d want 0", count);
        end
      end
    end
    in_valid = 1'b0; ack = 8'h00;
    n_cmp++;
    if (count !== 8'd44 || wrap_seen != 1) begin
      n_fail++; $display("FAIL stream_count got %0d want 44", count);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0]  ts;
    logic [15:0] tv;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; s = 3'(k); in_data = 16'($urandom_range(1, 65535)); ack = 8'h00;
      cycle();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (out_valid !== 8'h00 || count !== 8'd0) begin
      n_fail++; $display("FAIL async_flags out_valid=%h count=%0d want 00/0", out_valid, count);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (chan_out(k) !== 16'h0) begin
        n_fail++; $display("FAIL async_data ch%0d got %0d want 0", k, chan_out(k));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    ts = 3'($urandom_range(0, 7)); tv = 16'($urandom_range(1, 65535));
    in_valid = 1'b1; s = ts; in_data = tv;
    cycle();
    in_valid = 1'b0;
    n_cmp++;
    if (chan_out(ts) !== tv || out_valid !== (8'h01 << ts) || count !== 8'd1) begin
      n_fail++; $display("FAIL async_first ch%0d got %0d/%h/%0d want %0d/%h/1",
                         ts, chan_out(ts), out_valid, count, tv, 8'h01 << ts);
    end
  endtask

  task automatic test_random();
    logic stalled = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        in_valid = 1'($urandom_range(0, 1));
        s        = 3'($urandom_range(0, 7));
        in_data  = 16'($urandom);
      end
      ack = 8'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== m_ready()) begin
        n_fail++; $display("FAIL rand_ready i=%0d got %b want %b", i, in_ready, m_ready());
      end
      stalled = in_valid && !m_ready();
      cycle();
      n_cmp++;
      if (out_valid !== m_valid || count !== m_count) begin
        n_fail++; $display("FAIL rand_flags i=%0d got %h/%0d want %h/%0d", i, out_valid, count, m_valid, m_count);
      end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (chan_out(k) !== m_data[k]) begin
          n_fail++; $display("FAIL rand_data i=%0d ch%0d got %h want %h", i, k, chan_out(k), m_data[k]);
        end
      end
    end
    in_valid = 1'b0; ack = 8'h00;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ack = 8'h00; in_data = 16'h0; s = 3'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fill();
    test_backpressure();
    test_drain();
    test_spurious_ack();
    test_streaming();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
